// File: rtl/soc_bus_pkg.sv
// Shared definitions for the CPU-to-slave bus fabric: FSM encoding, address
// region field positions and the default error read data.
package soc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_ERROR  = 2'd3
  } bus_state_e;

  localparam int REGION_MSB = 31;
  localparam int REGION_LSB = 28;
  localparam int OFFSET_MSB = 27;
  localparam int OFFSET_LSB = 0;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEADBEEF;

  function automatic logic [3:0] region_of(input logic [31:0] addr);
    return addr[REGION_MSB:REGION_LSB];
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts stalled access cycles; terminal flags that the stall budget is spent.
module bus_timeout_counter #(
  parameter int unsigned TERMINAL = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  assign terminal = (count_q == 16'(TERMINAL));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !terminal) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/system_bus_fabric.sv
// Single-master bus fabric: decodes addr[31:28] to one of NUM_SLAVES regions,
// runs one access at a time, and aborts unmapped or stalled-out accesses.
module system_bus_fabric
  import soc_bus_pkg::*;
#(
  parameter int          NUM_SLAVES     = 4,
  parameter logic [15:0] SLAVE_MASK     = 16'h000F,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = DEFAULT_ERR_DATA
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_wdata,
  input  logic [3:0]               mem_wstrb,
  output logic [31:0]              mem_rdata,
  output logic [27:0]              s_address,
  output logic [31:0]              s_writeData,
  output logic [3:0]               s_byteenable,
  output logic [NUM_SLAVES-1:0]    s_read,
  output logic [NUM_SLAVES-1:0]    s_write,
  input  logic [32*NUM_SLAVES-1:0] s_readData,
  input  logic [NUM_SLAVES-1:0]    s_waitrequest,
  output logic                     bus_error,
  output logic [31:0]              error_addr,
  output logic [15:0]              error_count
);

  bus_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] error_addr_q, error_addr_d;
  logic [15:0] error_count_q, error_count_d;

  logic [3:0]  req_region;
  logic        req_mapped;
  logic        sel_wait;
  logic [31:0] sel_rdata;
  logic        is_read;
  logic        tmo_clear;
  logic        tmo_enable;
  logic        tmo_terminal;

  assign req_region = region_of(mem_addr);
  assign req_mapped = (int'(req_region) < NUM_SLAVES) && SLAVE_MASK[req_region];
  assign is_read    = (wstrb_q == 4'b0000);

  // Only the latched slave's stall and read data matter; others are ignored.
  always_comb begin
    sel_wait  = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == 4'(i)) begin
        sel_wait  = s_waitrequest[i];
        sel_rdata = s_readData[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_valid) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          sel_d   = req_region;
          state_d = req_mapped ? ST_ACCESS : ST_ERROR;
        end
      end
      ST_ACCESS: begin
        if (!sel_wait) begin
          state_d = ST_RESP;
        end else if (tmo_terminal) begin
          state_d = ST_ERROR;
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Error bookkeeping is updated on entry so it is visible during the pulse.
  always_comb begin
    error_addr_d  = error_addr_q;
    error_count_d = error_count_q;
    if (state_d == ST_ERROR) begin
      error_addr_d = addr_d;
      if (error_count_q != 16'hFFFF) begin
        error_count_d = error_count_q + 16'd1;
      end
    end
  end

  assign tmo_clear  = (state_d == ST_ACCESS) && (state_q != ST_ACCESS);
  assign tmo_enable = (state_q == ST_ACCESS) && sel_wait;

  bus_timeout_counter #(
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear    (tmo_clear),
    .enable   (tmo_enable),
    .terminal (tmo_terminal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      sel_q         <= '0;
      error_addr_q  <= '0;
      error_count_q <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      sel_q         <= sel_d;
      error_addr_q  <= error_addr_d;
      error_count_q <= error_count_d;
    end
  end

  always_comb begin
    s_read  = '0;
    s_write = '0;
    if (state_q == ST_ACCESS) begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (sel_q == 4'(i)) begin
          s_read[i]  = is_read;
          s_write[i] = !is_read;
        end
      end
    end
  end

  always_comb begin
    mem_ready = 1'b0;
    bus_error = 1'b0;
    mem_rdata = '0;
    case (state_q)
      ST_RESP: begin
        mem_ready = 1'b1;
        mem_rdata = is_read ? sel_rdata : 32'h0;
      end
      ST_ERROR: begin
        mem_ready = 1'b1;
        bus_error = 1'b1;
        mem_rdata = is_read ? ERR_DATA : 32'h0;
      end
      default: ;
    endcase
  end

  assign s_address    = addr_q[OFFSET_MSB:OFFSET_LSB];
  assign s_writeData  = wdata_q;
  assign s_byteenable = wstrb_q;
  assign error_addr   = error_addr_q;
  assign error_count  = error_count_q;

endmodule
